// File: rtl/result_writeback_arbiter_pkg.sv
// Shared types for the FPU result writeback arbiter: result bundle layout,
// select-control encodings and requester index constants.
package result_arb_pkg;

  localparam int unsigned REQ_ADDMUL  = 0;
  localparam int unsigned REQ_DIVSQRT = 1;
  localparam int unsigned REQ_CONVERT = 2;

  typedef enum logic [1:0] {
    SIGN_SEL_RESULT,
    SIGN_SEL_OPA,
    SIGN_SEL_OPB,
    SIGN_SEL_ZERO
  } sign_select_t;

  typedef enum logic [1:0] {
    EXP_SEL_RESULT,
    EXP_SEL_ZERO,
    EXP_SEL_ONES,
    EXP_SEL_MAX_FINITE
  } exponent_select_t;

  typedef enum logic [1:0] {
    FRAC_MSB_SEL_RESULT,
    FRAC_MSB_SEL_ZERO,
    FRAC_MSB_SEL_ONE,
    FRAC_MSB_SEL_OPA
  } fraction_msb_select_t;

  typedef enum logic [1:0] {
    FRAC_LSBS_SEL_RESULT,
    FRAC_LSBS_SEL_ZERO,
    FRAC_LSBS_SEL_ONES,
    FRAC_LSBS_SEL_OPA
  } fraction_lsbs_select_t;

  // Exponent is carried raw and interpreted as signed downstream.
  typedef struct packed {
    sign_select_t          sign_select;
    exponent_select_t      exponent_select;
    fraction_msb_select_t  fraction_msb_select;
    fraction_lsbs_select_t fraction_lsbs_select;
    logic                  result_sign;
    logic signed [9:0]     result_exponent;
    logic [31:0]           result_fraction;
  } result_bundle_t;

endpackage

// File: rtl/result_writeback_arbiter_if.sv
// Request/result handshake bundle between the FPU functional units, the
// writeback arbiter and the result selection stage.
interface result_writeback_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned TAG_W = $clog2(N_REQ)
) ();
  import result_arb_pkg::*;

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  result_bundle_t   req_bundle [N_REQ];
  logic             out_valid;
  logic             out_ready;
  result_bundle_t   out_bundle;
  logic [TAG_W-1:0] out_tag;

  // Units and result stage side
  modport master (
    output req_valid, req_bundle, out_ready,
    input  req_ready, out_valid, out_bundle, out_tag
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_bundle, out_ready,
    output req_ready, out_valid, out_bundle, out_tag
  );
endinterface

// File: rtl/result_writeback_arbiter_rr_grant.sv
// Combinational one-hot grant: first asserted request found when scanning
// upward (with wrap) from the pointer. Pointer of zero gives fixed priority.
module rr_grant #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned TAG_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  input  logic [TAG_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [TAG_W-1:0] idx_o
);

  int unsigned pos;
  logic        found;

  // Scan from the pointer, wrapping, and grant the first requester seen
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (en_i && !found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = TAG_W'(pos);
      end
    end
  end

endmodule

// File: rtl/result_writeback_arbiter.sv
// FPU result writeback arbiter: one-entry holding buffer per functional
// unit, single grant per cycle into a registered output slot tagged with
// the source unit.
// Build option: RESULT_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// undefined gives fixed priority with requester 0 (add/mul) highest.
module result_writeback_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned TAG_W = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  result_writeback_arbiter_if.slave   bus,
  output logic [$clog2(N_REQ+2)-1:0]  pending
);
  import result_arb_pkg::*;

  localparam int unsigned CNT_W = $clog2(N_REQ + 2);

  logic [N_REQ-1:0] buf_valid_q, buf_valid_d;
  result_bundle_t   buf_q [N_REQ];
  logic [N_REQ-1:0] grant, accept;
  logic [TAG_W-1:0] grant_idx, rr_ptr;
  logic             slot_free, any_grant;

  logic             out_valid_q, out_valid_d;
  result_bundle_t   out_bundle_q, out_bundle_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [CNT_W-1:0] pend_cnt;

  assign slot_free = ~out_valid_q | bus.out_ready;
  assign any_grant = |grant;

  rr_grant #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_grant (
    .req_i (buf_valid_q),
    .en_i  (slot_free),
    .ptr_i (rr_ptr),
    .gnt_o (grant),
    .idx_o (grant_idx)
  );

`ifdef RESULT_ARB_ROUND_ROBIN_EN
  logic [TAG_W-1:0] rr_ptr_q;

  // Pointer moves just past the most recently granted requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rr_ptr_q <= '0;
    else if (any_grant) rr_ptr_q <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0
                                                                    : grant_idx + TAG_W'(1);
  end
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // A buffer draining this cycle can be refilled in the same edge
  assign bus.req_ready = ~buf_valid_q | grant;
  assign accept        = bus.req_valid & bus.req_ready;
  assign buf_valid_d   = accept | (buf_valid_q & ~grant);

  // Buffer occupancy flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) buf_valid_q <= '0;
    else       buf_valid_q <= buf_valid_d;
  end

  // Buffer payload; only meaningful while its flag is set, so no reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (accept[i]) buf_q[i] <= bus.req_bundle[i];
    end
  end

  // Output slot next state: load on grant, clear on drain, else hold
  always_comb begin
    out_valid_d  = out_valid_q;
    out_bundle_d = out_bundle_q;
    out_tag_d    = out_tag_q;
    if (any_grant) begin
      out_valid_d  = 1'b1;
      out_bundle_d = buf_q[grant_idx];
      out_tag_d    = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Output slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_bundle_q <= out_bundle_d;
      out_tag_q    <= out_tag_d;
    end
  end

  // Occupancy: filled buffers plus the output slot
  always_comb begin
    pend_cnt = CNT_W'(out_valid_q);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pend_cnt = pend_cnt + CNT_W'(buf_valid_q[i]);
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_bundle = out_bundle_q;
  assign bus.out_tag    = out_tag_q;
  assign pending        = pend_cnt;

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Self-checking bench for result_writeback_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_result_writeback_arbiter;
  import result_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] pending;

  always #5 clk = ~clk;

  result_writeback_arbiter_if #(.N_REQ(3)) bus();

  result_writeback_arbiter #(.N_REQ(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pending (pending)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: each unit holds at most one waiting result; the output
  // slot holds one presented result.
  bit             m_hold [3];
  result_bundle_t m_held [3];
  bit             m_ov;
  result_bundle_t m_ob;
  int             m_ot;
  int             m_ptr;

  result_bundle_t obs_b [$];
  int             obs_t [$];
  int             obs_c [$];

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_hold[i] = 0;
      m_held[i] = '0;
    end
    m_ov  = 0;
    m_ob  = '0;
    m_ot  = 0;
    m_ptr = 0;
  endfunction

  // Winner among waiting units: lowest index, or closest at/after pointer
  function automatic int m_pick();
    int best = -1;
    int bestd = 99;
    for (int i = 0; i < 3; i++) begin
      if (m_hold[i]) begin
`ifdef RESULT_ARB_ROUND_ROBIN_EN
        int d = (i - m_ptr + 3) % 3;
`else
        int d = i;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic result_bundle_t rand_bundle();
    logic [63:0] r = {$urandom, $urandom};
    return result_bundle_t'(r[$bits(result_bundle_t)-1:0]);
  endfunction

  function automatic result_bundle_t mk(input logic [31:0] frac, input logic [9:0] expo);
    result_bundle_t b = '0;
    b.result_fraction = frac;
    b.result_exponent = expo;
    return b;
  endfunction

  // One cycle: drive at negedge, compare, advance the model, wait next negedge
  task automatic step(input logic [2:0] v, input result_bundle_t b0, input result_bundle_t b1,
                      input result_bundle_t b2, input logic ordy);
    result_bundle_t bi [3];
    bit             rdy [3];
    logic [2:0]     exp_rdy;
    int             w;
    int             cnt;
    bi[0] = b0; bi[1] = b1; bi[2] = b2;
    bus.req_valid     = v;
    bus.req_bundle[0] = b0;
    bus.req_bundle[1] = b1;
    bus.req_bundle[2] = b2;
    bus.out_ready     = ordy;
    #1;
    w   = (!m_ov || ordy) ? m_pick() : -1;
    cnt = m_ov ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      rdy[i]     = !m_hold[i] || (w == i);
      exp_rdy[i] = rdy[i];
      if (m_hold[i]) cnt++;
    end
    check_eq("out_valid", 64'(bus.out_valid), 64'(m_ov));
    check_eq("out_bundle", 64'(bus.out_bundle), 64'(m_ob));
    check_eq("out_tag", 64'(bus.out_tag), 64'(m_ot));
    check_eq("pending", 64'(pending), 64'(cnt));
    check_eq("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (bus.out_valid && ordy) begin
      obs_b.push_back(bus.out_bundle);
      obs_t.push_back(int'(bus.out_tag));
      obs_c.push_back(cyc);
    end
    if (w >= 0) begin
      m_ov       = 1;
      m_ob       = m_held[w];
      m_ot       = w;
      m_hold[w]  = 0;
      m_ptr      = (w + 1) % 3;
    end else if (ordy) begin
      m_ov = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (v[i] && rdy[i]) begin
        m_hold[i] = 1;
        m_held[i] = bi[i];
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, '0, '0, '0, 1'b1);
  endtask

  task automatic clear_obs();
    obs_b.delete();
    obs_t.delete();
    obs_c.delete();
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_pending", 64'(pending), 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'b111);
    check_eq("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check_eq("rst_out_bundle", 64'(bus.out_bundle), 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  result_bundle_t e_b;
  result_bundle_t exp_order [4];

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus.req_bundle[i] = '0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Single requester latency
    e_b = mk(32'h00C0_0000, 10'd130);
    step(3'b001, e_b, '0, '0, 1'b1);
    check_eq("t1_pend_buf", 64'(pending), 64'd1);
    step(3'b000, '0, '0, '0, 1'b1);
    check_eq("t1_valid", 64'(bus.out_valid), 64'd1);
    check_eq("t1_bundle", 64'(bus.out_bundle), 64'(e_b));
    check_eq("t1_tag", 64'(bus.out_tag), 64'd0);
    check_eq("t1_pend_out", 64'(pending), 64'd1);
    step(3'b000, '0, '0, '0, 1'b1);
    check_eq("t1_pend_empty", 64'(pending), 64'd0);
    check_eq("t1_drained", 64'(bus.out_valid), 64'd0);

    // Three-way contention, single burst
    do_reset();
    clear_obs();
    step(3'b111, mk(32'hA0, 10'd1), mk(32'hA1, 10'd2), mk(32'hA2, 10'd3), 1'b1);
    idle(5);
    check_eq("t2_count", 64'(obs_t.size()), 64'd3);
    if (obs_t.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("t2_tag", 64'(obs_t[i]), 64'(i));
        if (i > 0) check_eq("t2_b2b", 64'(obs_c[i] - obs_c[i-1]), 64'd1);
      end
    end

    // Contention with requester 0 streaming
    do_reset();
    clear_obs();
    step(3'b111, mk(32'hB0, 10'd1), mk(32'hB1, 10'd2), mk(32'hB2, 10'd3), 1'b1);
    for (int s = 1; s <= 4; s++) step(3'b001, mk(32'hB0 + 32'(s << 8), 10'd1), '0, '0, 1'b1);
    idle(6);
    check_eq("t2b_count", 64'(obs_t.size()), 64'd7);
    if (obs_t.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
`ifdef RESULT_ARB_ROUND_ROBIN_EN
        check_eq("t2b_tag", 64'(obs_t[i]), 64'(i));
`else
        check_eq("t2b_tag", 64'(obs_t[i]), 64'd0);
`endif
      end
    end

    // Backpressure: all streaming, output stalled for 6 cycles
    do_reset();
    clear_obs();
    for (int s = 0; s < 6; s++)
      step(3'b111, mk(32'hC000_0000 | 32'(s << 4) | 32'd0, 10'd5),
                   mk(32'hC000_0000 | 32'(s << 4) | 32'd1, 10'd5),
                   mk(32'hC000_0000 | 32'(s << 4) | 32'd2, 10'd5), 1'b0);
    #1;
    check_eq("t3_pend_sat", 64'(pending), 64'd4);
    check_eq("t3_rdy_low", 64'(bus.req_ready), 64'd0);
    idle(6);
`ifdef RESULT_ARB_ROUND_ROBIN_EN
    exp_order[0] = mk(32'hC000_0000, 10'd5);
    exp_order[1] = mk(32'hC000_0001, 10'd5);
    exp_order[2] = mk(32'hC000_0002, 10'd5);
    exp_order[3] = mk(32'hC000_0010, 10'd5);
`else
    exp_order[0] = mk(32'hC000_0000, 10'd5);
    exp_order[1] = mk(32'hC000_0010, 10'd5);
    exp_order[2] = mk(32'hC000_0001, 10'd5);
    exp_order[3] = mk(32'hC000_0002, 10'd5);
`endif
    check_eq("t3_count", 64'(obs_b.size()), 64'd4);
    if (obs_b.size() == 4)
      for (int i = 0; i < 4; i++) check_eq("t3_order", 64'(obs_b[i]), 64'(exp_order[i]));

    // Same-cycle refill of one buffer
    do_reset();
    clear_obs();
    for (int s = 0; s < 3; s++) begin
      step(3'b010, '0, mk(32'hD0 + 32'(s), 10'(s)), '0, 1'b1);
      #1;
      check_eq("t4_rdy1", 64'(bus.req_ready[1]), 64'd1);
    end
    idle(5);
    check_eq("t4_count", 64'(obs_b.size()), 64'd3);
    if (obs_b.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("t4_bundle", 64'(obs_b[i]), 64'(mk(32'hD0 + 32'(i), 10'(i))));
        check_eq("t4_tag", 64'(obs_t[i]), 64'd1);
        if (i > 0) check_eq("t4_b2b", 64'(obs_c[i] - obs_c[i-1]), 64'd1);
      end
    end

    // Reset while three results are in flight
    do_reset();
    step(3'b111, rand_bundle(), rand_bundle(), rand_bundle(), 1'b0);
    bus.req_valid = '0;
    #1;
    check_eq("t5_pend_before", 64'(pending), 64'd3);
    reset = 1'b1;
    #1;
    check_eq("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("t5_pending", 64'(pending), 64'd0);
    check_eq("t5_req_ready", 64'(bus.req_ready), 64'b111);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_obs();
    idle(4);
    check_eq("t5_no_stale", 64'(obs_b.size()), 64'd0);

    // Randomized traffic
    do_reset();
    for (int s = 0; s < 400; s++)
      step(3'($urandom_range(0, 7)), rand_bundle(), rand_bundle(), rand_bundle(),
           ($urandom_range(0, 9) < 7));
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_writeback_arbiter.md
# result_writeback_arbiter

Shares the single result-selection/writeback stage between the FPU's functional units: the pipelined add/mul unit, the iterative div/sqrt unit and the conversion unit. Each unit hands over a completed result bundle (select controls plus raw exponent/fraction) through a valid/ready handshake into a one-entry holding buffer. A grant-and-register stage forwards one bundle per cycle to the result control and selection logic, tagged with the source unit.

## Interface
Parameters:
- N_REQ, 3, number of requesting units; requester 0 = add/mul, 1 = div/sqrt, 2 = convert.
- TAG_W, $clog2(N_REQ), width of source tag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-unit result valid.
- req_ready  out  N_REQ  per-unit buffer can accept.
- req_bundle  in  N_REQ x result_bundle_t  per-unit result bundle.
- out_valid  out  1  bundle presented to result stage.
- out_ready  in  1  result stage accepts.
- out_bundle  out  result_bundle_t  granted bundle.
- out_tag  out  TAG_W  index of source requester.
- pending  out  $clog2(N_REQ+2)  occupied buffers plus output register.

## Operation
- Per-requester buffer: flag buf_valid[i] plus bundle register. Loads on req_valid[i] & req_ready[i].
- req_ready[i] = ~buf_valid[i] | grant[i]. This allows back-to-back accept while the entry drains the same cycle.
- Output slot free = ~out_valid | out_ready.
- grant is one-hot among buf_valid. It is nonzero only when the slot is free. At most one grant per cycle.
- On grant[i]: the output register loads buf[i] and out_tag = i. out_valid sets. buf_valid[i] clears unless refilled in the same cycle.
- On out_ready & out_valid with no grant: out_valid clears. out_bundle holds its last value.
- While out_valid & ~out_ready: the output register holds and no grants occur. Buffers fill, then req_ready drops.
- Bundle contents pass through unmodified. Overflow/underflow/zero decisions belong to the downstream result control.
- pending = popcount(buf_valid) + out_valid. The range is 0..N_REQ+1.

## Timing
- Reset values: out_valid 0, out_bundle all zero, out_tag 0, pending 0, all buf_valid 0, RR pointer 0.
- req_ready is all ones during and after reset, since it is derived from buf_valid.
- Latency: accept at edge k, granted at edge k+1, out_valid high in cycle k+2 (2 edges) when uncontended.
- Throughput: 1 bundle/cycle aggregate; 1 bundle/cycle per requester when it is the only requester.
- Simultaneous grant and refill of the same buffer: the new bundle is stored and the old one is forwarded. There is no bubble and no loss.
- Simultaneous out_ready and grant: the output register is replaced in the same edge with no bubble.
- All N_REQ buffers full and output stalled: all req_ready are 0, pending = N_REQ+1, and nothing is dropped or duplicated.
- Reset asserted mid-operation: all in-flight bundles are discarded immediately (asynchronously) and the outputs go to their reset values.
- req_bundle must be stable only in the accept cycle. out_bundle and out_tag are stable while out_valid & ~out_ready.

## Configuration
- Macro: RESULT_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The pointer advances to (granted index + 1) mod N_REQ after each grant.
  - The search starts at the pointer.
  - Worst-case wait is N_REQ-1 grants.
- Undefined: fixed priority, lowest index wins (add/mul highest).
  - The RR pointer is not implemented.
  - Starvation of higher indices under continuous requester-0 traffic is accepted behaviour.

## Structure
- Package result_arb_pkg contains:
  - result_bundle_t: packed struct of sign::sign_select, exponent::exponent_select, fraction_msb::fraction_msb_select, fraction_lsbs::fraction_lsbs_select, result_sign, result_exponent[9:0] (signed-interpreted), result_fraction[31:0].
  - Requester index constants REQ_ADDMUL = 0, REQ_DIVSQRT = 1, REQ_CONVERT = 2.
- Sub-module rr_grant: combinational one-hot grant from request vector, enable and pointer. The pointer register lives in the parent.

## Test plan
- Single requester: req 0 valid for one cycle with exponent 10'd130 and fraction 32'h00C00000 -> out_valid in cycle 2 with identical bundle, out_tag 0, pending 1 then 0.
- Contention, RR defined: all three requesters valid in the same cycle with out_ready held 1 -> out_tag sequence 0,1,2 on consecutive cycles. Undefined -> same sequence, but with req 0 kept valid each cycle the tags are 0,0,0…
- Backpressure: out_ready 0 for 6 cycles with all requesters streaming -> pending saturates at 4, all req_ready 0, and after release exactly 4 distinct bundles emerge in order.
- Same-cycle refill: req 1 streams bundles A, B, C on consecutive cycles with out_ready 1 -> req_ready[1] stays 1 and the output shows A, B, C back-to-back.
- Reset mid-flight: assert reset with pending 3 -> out_valid 0, pending 0 and req_ready 3'b111 immediately; no stale bundle after deassert.
